mult_8bit_seq: RTL



---
 rtl/mult_8bit_seq_pkg.sv | 20 ++
 rtl/adder_8bit.sv | 20 ++
 rtl/mult_8bit_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/mult_8bit_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: widths, step count,
// FSM state encoding and the carry-recovery helper.
package mult_8bit_seq_pkg;

    localparam int unsigned ALU_W     = 8;
    localparam int unsigned MUL_STEPS = 8;

    // Encoding 2'd3 is never entered and is decoded as idle by the FSM.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Rebuilds the adder's discarded MSB carry from the operand and sum sign bits.
    function automatic logic carry_out(input logic hi7, input logic m7, input logic s7);
        return (hi7 & m7) | ((hi7 ^ m7) & ~s7);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// Existing 8-bit ripple-carry adder; the carry out of the MSB is not brought out.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum
);

    logic cy;

    always_comb begin
        cy  = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
        end
    end

endmodule

// File: rtl/mult_8bit_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one adder_8bit.
// Operands latch on start, one partial-product step per clock, product held in P.
module mult_8bit_seq
    import mult_8bit_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        busy,
    output logic        done,
    output logic [15:0] P
);

    state_e           state;
    logic [ALU_W-1:0] m;
    logic [ALU_W-1:0] hi;
    logic [ALU_W-1:0] lo;
    logic [2:0]       cnt;
    logic [15:0]      p_r;
    logic             busy_r;
    logic             done_r;

    logic [ALU_W-1:0] sum;
    logic             carry;
    logic [ALU_W-1:0] hi_nxt;
    logic [ALU_W-1:0] lo_nxt;

    adder_8bit u_adder (
        .a   (hi),
        .b   (m),
        .cin (1'b0),
        .sum (sum)
    );

    // One step: conditionally add M into HI, then shift {carry, HI, LO} right by one.
    always_comb begin
        carry = carry_out(hi[7], m[7], sum[7]);
        if (lo[0]) begin
            {hi_nxt, lo_nxt} = {carry, sum, lo[7:1]};
        end else begin
            {hi_nxt, lo_nxt} = {1'b0, hi, lo[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            p_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                StRun: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(MUL_STEPS - 1)) begin
                        p_r    <= {hi_nxt, lo_nxt};
                        state  <= StDone;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                // Idle, done and the unused encoding all accept a new start.
                default: begin
                    done_r <= 1'b0;
                    if (start) begin
                        m      <= A;
                        lo     <= B;
                        hi     <= '0;
                        cnt    <= '0;
                        state  <= StRun;
                        busy_r <= 1'b1;
                    end else begin
                        state  <= StIdle;
                        busy_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign P    = p_r;

endmodule
